// File: rtl/bb_bank_pkg.sv
// Shared definitions for the bidirectional pad bank: FSM states, pull-mode
// selectors, counter width and saturating counter helpers.
package bb_bank_pkg;

  // Direction FSM states; RX is the reset state.
  typedef enum logic [1:0] {
    ST_RX      = 2'd0,
    ST_TURN_TX = 2'd1,
    ST_TX      = 2'd2,
    ST_TURN_RX = 2'd3
  } bank_state_t;

  // Turnaround and stability counters share one width; 4 bits covers 1..15.
  localparam int CNT_W = 4;

  // Pull-mode selectors, compared against the PULLMODE parameter string.
  localparam logic [31:0] PULL_NONE = "NONE";
  localparam logic [31:0] PULL_UP   = "UP";
  localparam logic [31:0] PULL_DOWN = "DOWN";

  // Increment that stops at the given limit instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                               input logic [CNT_W-1:0] limit);
    return (value >= limit) ? limit : value + 1'b1;
  endfunction

  // Decrement that stops at zero instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] value);
    return (value == '0) ? '0 : value - 1'b1;
  endfunction

endpackage

// File: rtl/BB.sv
// Behavioural model of the plain bidirectional pad buffer (T=1 tristates the
// pad). Leave this file out of a build where the vendor library supplies BB.
module BB (
  input  logic I,
  input  logic T,
  output logic O,
  inout  wire  B
);
  assign B = T ? 1'bz : I;
  assign O = B;
endmodule

// File: rtl/BBPD.sv
// Behavioural model of the bidirectional pad buffer with a weak pull-down.
// Leave this file out of a build where the vendor library supplies BBPD.
module BBPD (
  input  logic I,
  input  logic T,
  output logic O,
  inout  wire  B
);
  pulldown (B);
  assign B = T ? 1'bz : I;
  assign O = B;
endmodule

// File: rtl/BBPU.sv
// Behavioural model of the bidirectional pad buffer with a weak pull-up.
// Leave this file out of a build where the vendor library supplies BBPU.
module BBPU (
  input  logic I,
  input  logic T,
  output logic O,
  inout  wire  B
);
  pullup (B);
  assign B = T ? 1'bz : I;
  assign O = B;
endmodule

// File: rtl/bb_bank_rxfilt.sv
// Receive path: two-flop synchroniser on every pad bit followed by a
// stability filter that delivers a word once it has been steady long enough.
module bb_bank_rxfilt
  import bb_bank_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int FILTER = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_en,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid
);

  localparam logic [CNT_W-1:0] FILT_LIM = CNT_W'(FILTER);

  logic [WIDTH-1:0] sync_a;
  logic [WIDTH-1:0] sync_b;
  logic [WIDTH-1:0] prev_word;
  logic [CNT_W-1:0] stable_cnt;
  logic [CNT_W-1:0] stable_next;
  logic             stable;
  logic             fire;

  // Synchronise the pads and keep last cycle's synchronised word; runs in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a    <= '0;
      sync_b    <= '0;
      prev_word <= '0;
    end else begin
      sync_a    <= pad_in;
      sync_b    <= sync_a;
      prev_word <= sync_b;
    end
  end

  // Count steady cycles only while receiving; a delivery fires on the cycle the count reaches the limit with a new word.
  always_comb begin
    stable_next = '0;
    fire        = 1'b0;
    stable      = (sync_b == prev_word);
    if (rx_en && stable) begin
      stable_next = sat_inc(stable_cnt, FILT_LIM);
    end
    fire = rx_en && stable && (stable_next == FILT_LIM) && (sync_b != rx_data);
  end

  // Register the stability count, the delivered word and the one-cycle valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
    end else begin
      stable_cnt <= stable_next;
      rx_valid   <= fire;
      if (fire) begin
        rx_data <= sync_b;
      end
    end
  end

endmodule

// File: rtl/bb_bank.sv
// Bidirectional pad bank: direction FSM with bus turnaround in both
// directions, registered transmit word and output enable, filtered receive.
module bb_bank
  import bb_bank_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] PULLMODE    = PULL_NONE,
  parameter int          TURN_CYCLES = 2,
  parameter int          FILTER      = 3
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             dir_req,
  output logic             dir_ack,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  (* iopad_external_pin *)
  inout  wire  [WIDTH-1:0] B
);

  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES);

  bank_state_t      state;
  bank_state_t      state_next;
  logic [CNT_W-1:0] turn_cnt;
  logic [CNT_W-1:0] turn_next;
  logic             oe;
  logic             pad_tri;
  logic [WIDTH-1:0] out_word;
  logic [WIDTH-1:0] pad_in;
  logic             rx_en;

  assign dir_ack  = (state == ST_TX);
  assign tx_ready = (state == ST_TX) && dir_req;
  assign pad_tri  = ~oe;
  assign rx_en    = (state == ST_RX);

  // Next-state logic: turnaround toward TX can be abandoned, turnaround toward RX always completes.
  always_comb begin
    state_next = state;
    turn_next  = turn_cnt;
    case (state)
      ST_RX: begin
        if (dir_req) begin
          state_next = ST_TURN_TX;
          turn_next  = TURN_LOAD;
        end
      end
      ST_TURN_TX: begin
        if (!dir_req) begin
          state_next = ST_RX;
          turn_next  = '0;
        end else begin
          turn_next = sat_dec(turn_cnt);
          if (turn_next == '0) begin
            state_next = ST_TX;
          end
        end
      end
      ST_TX: begin
        if (!dir_req) begin
          state_next = ST_TURN_RX;
          turn_next  = TURN_LOAD;
        end
      end
      ST_TURN_RX: begin
        turn_next = sat_dec(turn_cnt);
        if (turn_next == '0) begin
          state_next = ST_RX;
        end
      end
      default: begin
        state_next = ST_RX;
        turn_next  = '0;
      end
    endcase
  end

  // State, turnaround counter and output enable; the enable follows the next state so it changes on the same edge.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= ST_RX;
      turn_cnt <= '0;
      oe       <= 1'b0;
    end else begin
      state    <= state_next;
      turn_cnt <= turn_next;
      oe       <= (state_next == ST_TX);
    end
  end

  // Output word register, loaded only on an accepted transmit handshake.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      out_word <= '0;
    end else if (tx_valid && tx_ready) begin
      out_word <= tx_data;
    end
  end

  // One pad buffer per bit, with the pull selected at elaboration time.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    if (PULLMODE == PULL_UP) begin : g_pu
      BBPU u_pad (.I(out_word[i]), .T(pad_tri), .O(pad_in[i]), .B(B[i]));
    end else if (PULLMODE == PULL_DOWN) begin : g_pd
      BBPD u_pad (.I(out_word[i]), .T(pad_tri), .O(pad_in[i]), .B(B[i]));
    end else begin : g_np
      BB u_pad (.I(out_word[i]), .T(pad_tri), .O(pad_in[i]), .B(B[i]));
    end
  end

  bb_bank_rxfilt #(
    .WIDTH (WIDTH),
    .FILTER(FILTER)
  ) u_rxfilt (
    .clk     (CLK),
    .rst_n   (RSTN),
    .rx_en   (rx_en),
    .pad_in  (pad_in),
    .rx_data (rx_data),
    .rx_valid(rx_valid)
  );

endmodule

// File: doc/bb_bank.md
BB_BANK -- requirements
Module: bb_bank

Interface
REQ-001 Parameter WIDTH, default 8: number of bidirectional pad channels, range 1..64.
REQ-002 Parameter PULLMODE, default "NONE": per-pad pull, one of "NONE", "UP" or "DOWN".
REQ-003 Parameter TURN_CYCLES, default 2: bus turnaround length in cycles, range 1..15.
REQ-004 Parameter FILTER, default 3: receive stability length in cycles, range 1..15.
REQ-005 CLK  input  1  single clock; all state updates on its rising edge.
REQ-006 RSTN  input  1  reset, asynchronous and active-low.
REQ-007 dir_req  input  1  direction request; 1 = transmit, 0 = receive.
REQ-008 dir_ack  output  1  high while the bank is in TX.
REQ-009 tx_data  input  WIDTH  word to drive.
REQ-010 tx_valid  input  1  tx_data is valid.
REQ-011 tx_ready  output  1  the bank accepts tx_data this cycle.
REQ-012 rx_data  output  WIDTH  last delivered received word.
REQ-013 rx_valid  output  1  one-cycle pulse marking a new rx_data.
REQ-014 B  inout  WIDTH  pad pins, carrying the iopad_external_pin attribute.

Function
REQ-015 The FSM SHALL have four states: RX (reset state), TURN_TX, TX and TURN_RX.
REQ-016 In RX, dir_req=1 SHALL move the FSM to TURN_TX and load the turnaround counter with TURN_CYCLES.
REQ-017 TURN_TX SHALL decrement the counter each cycle and enter TX on the cycle the counter reaches 0; throughout TURN_TX the pads remain tristated.
REQ-018 dir_req=0 during TURN_TX SHALL return the FSM to RX on the next cycle; the pads are never driven in this case.
REQ-019 tx_ready SHALL equal (state==TX) AND dir_req, combinationally.
REQ-020 On tx_valid AND tx_ready, the output data register SHALL load tx_data; the pad reflects the new word one cycle later; the register holds its value otherwise.
REQ-021 The registered output enable SHALL be active only in TX; the pads are driven from the first TX cycle with the held output register value.
REQ-022 In TX, dir_req=0 SHALL move the FSM to TURN_RX, and the output enable SHALL deassert on that same edge.
REQ-023 TURN_RX SHALL always run the full TURN_CYCLES count, then enter RX; dir_req=1 during TURN_RX has no effect until RX is reached.
REQ-024 Each pad input SHALL pass through a two-flop synchroniser, whatever the state.
REQ-025 In RX, a stability counter SHALL increment while the synchronised word equals its previous-cycle value, and SHALL reset to 0 on any change.
REQ-026 When the stability counter reaches FILTER and the synchronised word differs from rx_data, the block SHALL load rx_data and pulse rx_valid for exactly one cycle.
REQ-027 A word held beyond FILTER cycles SHALL NOT produce a repeat rx_valid.
REQ-028 The stability counter SHALL be cleared on entry to RX and held at 0 outside RX, so rx_valid never asserts outside RX.
REQ-029 Counters SHALL saturate and never wrap.

Reset
REQ-030 Asserting RSTN low SHALL apply immediately, from any state, including mid-turnaround and mid-transfer.
REQ-031 Reset values: state=RX, output enable inactive (pads tristated), output data 0, rx_data 0, rx_valid 0, both counters 0, synchroniser flops 0.
REQ-032 On RSTN release the FSM SHALL start in RX, and the first rx_valid SHALL occur no earlier than 2+FILTER cycles later.

Structure
REQ-033 The state encoding, the PULLMODE string constants and the counter width constant SHALL live in the shared package bb_bank_pkg.
REQ-034 A per-bit generate loop SHALL instantiate BB, BBPU or BBPD according to PULLMODE.
REQ-035 The natural sub-module is bb_bank_rxfilt (synchroniser plus stability filter); the FSM stays in bb_bank.

Verification (WIDTH=8, TURN_CYCLES=2, FILTER=3)
REQ-036 After reset, pads externally driven to 0x5A and held -> exactly one rx_valid, with rx_data=0x5A, 5 cycles after the first sampled edge; no further pulses.
REQ-037 dir_req=1 from RX -> tx_ready rises 3 cycles later; tx_data=0xC3 accepted -> B=0xC3 on the following cycle.
REQ-038 dir_req=1 for 1 cycle only, then dropped during TURN_TX -> back in RX, B never driven, tx_ready never high.
REQ-039 In TX, dir_req=0 and re-asserted 1 cycle later -> B released next edge, 2 TURN_RX cycles, 1 RX cycle, then 2 TURN_TX cycles before TX.
REQ-040 Pads toggle 0x11/0x22 every 2 cycles -> no rx_valid; then hold 0x22 -> one pulse with rx_data=0x22.
REQ-041 RSTN asserted in TX while driving 0xFF -> B tristated asynchronously, all outputs at reset values.
